ipsxe_floating_point_normalize_16bit_v1_0: RTL and testbench
============================================================

IPSXE_FLOATING_POINT_NORMALIZE_16BIT_V1_0 -- requirements
Module: ipsxe_floating_point_normalize_16bit_v1_0

Interface
REQ-001 The block SHALL have one parameter: EXP_WIDTH, default 8, width of the biased exponent field.
REQ-002 i_clk  input  1  sole clock; all state on rising edge.
REQ-003 i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_valid  input  1  upstream data valid.
REQ-005 o_ready  output  1  block can accept input this cycle.
REQ-006 i_mant  input  16  unnormalized magnitude from the add/sub datapath; bit 15 has the weight of i_exp.
REQ-007 i_exp  input  EXP_WIDTH  biased exponent associated with i_mant[15].
REQ-008 i_sign  input  1  result sign, passed through.
REQ-009 o_valid  output  1  output data valid.
REQ-010 i_ready  input  1  downstream can accept output.
REQ-011 o_mant  output  16  normalized mantissa.
REQ-012 o_exp  output  EXP_WIDTH  adjusted exponent.
REQ-013 o_sign  output  1  sign aligned with o_mant.
REQ-014 o_zero  output  1  result is exact zero.
REQ-015 o_uflow  output  1  result is denormal (nonzero, exponent clamped to 0).

Function
REQ-016 Transfer occurs on a cycle with valid and ready both high (per side); no other cycle transfers data.
REQ-017 idx = position of the leftmost 1 in i_mant (0..15); shift = 15 - idx.
REQ-018 i_mant == 0: o_zero=1, o_mant=0, o_exp=0, o_uflow=0, o_sign = i_sign.
REQ-019 i_mant != 0 and i_exp > shift: o_mant = i_mant << shift (bit 15 = 1), o_exp = i_exp - shift, o_uflow=0.
REQ-020 i_mant != 0 and i_exp <= shift: o_mant = i_mant << max(i_exp-1, 0), o_exp=0, o_uflow=1.
REQ-021 Shift is logical left, zero fill, result truncated to 16 bits; no exponent wrap-around permitted.
REQ-022 Two-stage pipeline: S1 registers operands, idx and shift; S2 registers shifted mantissa, exponent and flags; latency 2 cycles from input transfer to o_valid, given i_ready high.
REQ-023 Throughput one result per cycle while i_ready high.
REQ-024 S2 loads when S2 empty or i_ready high; S1 loads when S1 empty or S2 loads; o_ready = S1 empty or S2 loads (combinational i_ready-to-o_ready path permitted).
REQ-025 While o_valid=1 and i_ready=0, all outputs SHALL remain stable.
REQ-026 With i_ready held low, the block SHALL hold exactly two results then deassert o_ready; no data lost, duplicated or reordered.
REQ-027 Simultaneous output drain and input accept in a full pipeline SHALL advance both stages in the same cycle.

Reset
REQ-028 While i_rst_n=0 at a clock edge: S1/S2 valid flags and all data registers clear to 0; o_valid=0, o_mant=0, o_exp=0, o_sign=0, o_zero=0, o_uflow=0.
REQ-029 o_ready SHALL be 0 while i_rst_n=0 and 1 in the first cycle after release.
REQ-030 Reset mid-operation SHALL discard all in-flight results; no partial output after release.

Structure
REQ-031 Mantissa width (16), index width (4) and shift-amount width (4) SHALL be shared constants in the floating-point common package/include used by the add/sub path.
REQ-032 S1 SHALL instantiate ipsxe_floating_point_find_one_16bit_v1_0 for idx; no other sub-module.

Verification
REQ-033 i_mant=16'h0100, i_exp=20, i_ready=1 -> 2 cycles later o_mant=16'h8000, o_exp=13, o_zero=0, o_uflow=0.
REQ-034 i_mant=16'h0000, i_exp=50, i_sign=1 -> o_zero=1, o_mant=0, o_exp=0, o_sign=1.
REQ-035 i_mant=16'h0010, i_exp=5 -> o_mant=16'h0100, o_exp=0, o_uflow=1; i_mant=16'h8001, i_exp=1 -> o_mant=16'h8001, o_exp=1, o_uflow=0.
REQ-036 Three back-to-back inputs, i_ready low from first o_valid -> o_ready low after second accept, outputs stable; i_ready high -> three results in order, none lost.
REQ-037 i_rst_n low one cycle with both stages valid -> next cycle o_valid=0, o_ready=0 during reset, o_ready=1 after release, no stale result.

Source files
------------

// File: rtl/ipsxe_floating_point_normalize_16bit_v1_0_pkg.sv
// rtl/ipsxe_floating_point_normalize_16bit_v1_0_pkg.sv - shared floating-point constants and helpers
package ipsxe_floating_point_normalize_16bit_v1_0_pkg;

  // Datapath widths shared with the add/sub path
  localparam int MANT_W  = 16;
  localparam int IDX_W   = 4;
  localparam int SHIFT_W = 4;

  // Bit position of the mantissa MSB, expressed at shift width
  localparam logic [SHIFT_W-1:0] MSB_POS = SHIFT_W'(MANT_W - 1);

  // Outcome of normalizing one operand
  typedef enum logic [1:0] {
    NORM_ZERO   = 2'd0,
    NORM_NORMAL = 2'd1,
    NORM_DENORM = 2'd2
  } norm_class_e;

  // Left shift that moves the leading one at position idx up to the MSB
  function automatic logic [SHIFT_W-1:0] shift_for_idx(input logic [IDX_W-1:0] idx);
    return MSB_POS - SHIFT_W'(idx);
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_find_one_16bit_v1_0.sv
// rtl/ipsxe_floating_point_find_one_16bit_v1_0.sv - leftmost-one detector for a 16-bit mantissa
module ipsxe_floating_point_find_one_16bit_v1_0
  import ipsxe_floating_point_normalize_16bit_v1_0_pkg::*;
(
  input  logic [MANT_W-1:0] data,
  output logic [IDX_W-1:0]  idx,
  output logic              found
);

  // Scan upward so the highest set bit wins; idx is 0 when data is all zero
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int b = 0; b < MANT_W; b++) begin
      if (data[b]) begin
        idx   = IDX_W'(b);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ipsxe_floating_point_normalize_16bit_v1_0.sv
// rtl/ipsxe_floating_point_normalize_16bit_v1_0.sv - two-stage mantissa normalizer with valid/ready flow control
module ipsxe_floating_point_normalize_16bit_v1_0
  import ipsxe_floating_point_normalize_16bit_v1_0_pkg::*;
#(
  parameter int EXP_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [MANT_W-1:0]    i_mant,
  input  logic [EXP_WIDTH-1:0] i_exp,
  input  logic                 i_sign,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [MANT_W-1:0]    o_mant,
  output logic [EXP_WIDTH-1:0] o_exp,
  output logic                 o_sign,
  output logic                 o_zero,
  output logic                 o_uflow
);

  // Exponent and shift are compared at a common width so neither side truncates
  localparam int CMP_W = (EXP_WIDTH > SHIFT_W) ? EXP_WIDTH : SHIFT_W;

  // Stage 1 state: operands plus leading-one position
  logic                 s1_valid;
  logic [MANT_W-1:0]    s1_mant;
  logic [EXP_WIDTH-1:0] s1_exp;
  logic                 s1_sign;
  logic                 s1_zero;
  logic [IDX_W-1:0]     s1_idx;
  logic [SHIFT_W-1:0]   s1_shift;

  // Stage 2 state: normalized result
  logic                 s2_valid;
  logic [MANT_W-1:0]    s2_mant;
  logic [EXP_WIDTH-1:0] s2_exp;
  logic                 s2_sign;
  logic                 s2_zero;
  logic                 s2_uflow;

  // Flow control
  logic s1_load;
  logic s2_load;

  // Leading-one detector on the incoming operand
  logic [IDX_W-1:0] fo_idx;
  logic             fo_found;

  ipsxe_floating_point_find_one_16bit_v1_0 u_find_one (
    .data  (i_mant),
    .idx   (fo_idx),
    .found (fo_found)
  );

  // A stage may take new data when it is empty or its contents are moving on
  assign s2_load = !s2_valid || i_ready;
  assign s1_load = !s1_valid || s2_load;
  assign o_ready = i_rst_n && s1_load;

  // Stage 1 register: capture operand, leading-one index and required shift
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_exp   <= '0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_idx   <= '0;
      s1_shift <= '0;
    end else if (s1_load) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_mant  <= i_mant;
        s1_exp   <= i_exp;
        s1_sign  <= i_sign;
        s1_zero  <= !fo_found;
        s1_idx   <= fo_idx;
        s1_shift <= shift_for_idx(fo_idx);
      end
    end
  end

  // Stage 2 combinational normalization
  logic [CMP_W-1:0]     exp_ext;
  logic [CMP_W-1:0]     shift_ext;
  norm_class_e          n_class;
  logic [SHIFT_W-1:0]   n_lshift;
  logic [MANT_W-1:0]    n_mant;
  logic [EXP_WIDTH-1:0] n_exp;

  assign exp_ext   = CMP_W'(s1_exp);
  assign shift_ext = CMP_W'(s1_shift);

  // Classify the operand, then pick the shift and exponent for that class
  always_comb begin
    n_class  = NORM_ZERO;
    n_lshift = '0;
    n_exp    = '0;
    n_mant   = '0;
    if (s1_zero) begin
      n_class = NORM_ZERO;
    end else if (exp_ext > shift_ext) begin
      n_class  = NORM_NORMAL;
      n_lshift = s1_shift;
      n_exp    = EXP_WIDTH'(exp_ext - shift_ext);
    end else begin
      // Exponent would reach zero or below: shift only until it bottoms out at 1,
      // then report a denormal with exponent field 0
      n_class  = NORM_DENORM;
      n_lshift = (exp_ext == '0) ? '0 : SHIFT_W'(exp_ext - CMP_W'(1));
    end
    if (n_class != NORM_ZERO) begin
      n_mant = s1_mant << n_lshift;
    end
  end

  // Stage 2 register: hold the normalized result until downstream takes it
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_mant  <= '0;
      s2_exp   <= '0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_uflow <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mant  <= n_mant;
        s2_exp   <= n_exp;
        s2_sign  <= s1_sign;
        s2_zero  <= (n_class == NORM_ZERO);
        s2_uflow <= (n_class == NORM_DENORM);
      end
    end
  end

  assign o_valid = s2_valid;
  assign o_mant  = s2_mant;
  assign o_exp   = s2_exp;
  assign o_sign  = s2_sign;
  assign o_zero  = s2_zero;
  assign o_uflow = s2_uflow;

endmodule

// File: tb/tb_ipsxe_floating_point_normalize_16bit_v1_0.sv
// tb/tb_ipsxe_floating_point_normalize_16bit_v1_0.sv - scoreboard bench for the 16-bit normalizer
module tb_ipsxe_floating_point_normalize_16bit_v1_0;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_mant;
  logic [7:0]  i_exp;
  logic        i_sign;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_mant;
  logic [7:0]  o_exp;
  logic        o_sign;
  logic        o_zero;
  logic        o_uflow;

  typedef struct packed {
    logic [15:0] mant;
    logic [7:0]  exp;
    logic        sign;
    logic        zero;
    logic        uflow;
  } res_t;

  res_t sb[$];
  int   passed = 0;
  int   total  = 0;

  ipsxe_floating_point_normalize_16bit_v1_0 #(.EXP_WIDTH(8)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_mant  (i_mant),
    .i_exp   (i_exp),
    .i_sign  (i_sign),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_mant  (o_mant),
    .o_exp   (o_exp),
    .o_sign  (o_sign),
    .o_zero  (o_zero),
    .o_uflow (o_uflow)
  );

  always #5 i_clk = ~i_clk;

  function automatic res_t model(input logic [15:0] m, input logic [7:0] e, input logic s);
    res_t r;
    int   idx;
    int   sh;
    int   ei;
    r.sign  = s;
    r.zero  = 1'b0;
    r.uflow = 1'b0;
    r.mant  = '0;
    r.exp   = '0;
    if (m == 16'h0000) begin
      r.zero = 1'b1;
    end else begin
      idx = 0;
      for (int b = 0; b < 16; b++) if (m[b]) idx = b;
      sh = 15 - idx;
      ei = int'(e);
      if (ei > sh) begin
        r.mant = m << sh;
        r.exp  = 8'(ei - sh);
      end else begin
        r.mant  = m << ((ei > 0) ? ei - 1 : 0);
        r.uflow = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic res_t outs();
    return {o_mant, o_exp, o_sign, o_zero, o_uflow};
  endfunction

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_mant  = 16'h1234;
    i_exp   = 8'd9;
    i_sign  = 1'b1;
    repeat (3) @(negedge i_clk);
    #1;
    total++;
    if (o_ready !== 1'b0) $display("FAIL reset_ready got %b expected 0", o_ready); else passed++;
    total++;
    if ({o_valid, outs()} !== 28'h0) $display("FAIL reset_outputs got %h expected 0", {o_valid, outs()}); else passed++;
    i_rst_n = 1'b1;
    #1;
    total++;
    if (o_ready !== 1'b1) $display("FAIL release_ready got %b expected 1", o_ready); else passed++;
  endtask

  task automatic test_directed();
    logic [15:0] vm[10] = '{16'h0100, 16'h0000, 16'h0010, 16'h8001, 16'h0001,
                            16'h0001, 16'h0003, 16'hFFFF, 16'h0001, 16'h7FFF};
    logic [7:0]  ve[10] = '{8'd20, 8'd50, 8'd5, 8'd1, 8'd15, 8'd16, 8'd0, 8'd255, 8'd255, 8'd1};
    logic        vs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    res_t        vx[10] = '{
      {16'h8000, 8'd13,  1'b0, 1'b0, 1'b0},
      {16'h0000, 8'd0,   1'b1, 1'b1, 1'b0},
      {16'h0100, 8'd0,   1'b0, 1'b0, 1'b1},
      {16'h8001, 8'd1,   1'b1, 1'b0, 1'b0},
      {16'h4000, 8'd0,   1'b0, 1'b0, 1'b1},
      {16'h8000, 8'd1,   1'b0, 1'b0, 1'b0},
      {16'h0003, 8'd0,   1'b1, 1'b0, 1'b1},
      {16'hFFFF, 8'd255, 1'b0, 1'b0, 1'b0},
      {16'h8000, 8'd240, 1'b1, 1'b0, 1'b0},
      {16'h7FFF, 8'd0,   1'b0, 1'b0, 1'b1}};
    res_t e;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge i_clk);
      i_ready = 1'b1;
      i_valid = (cyc < 10);
      if (cyc < 10) begin
        i_mant = vm[cyc];
        i_exp  = ve[cyc];
        i_sign = vs[cyc];
      end
      #1;
      total++;
      if (o_ready !== 1'b1) $display("FAIL dir_throughput_ready cyc %0d got %b expected 1", cyc, o_ready); else passed++;
      total++;
      if (o_valid !== (cyc >= 2 && cyc < 12))
        $display("FAIL dir_latency_valid cyc %0d got %b expected %b", cyc, o_valid, (cyc >= 2 && cyc < 12));
      else passed++;
      if (o_valid && i_ready) begin
        total++;
        if (sb.size() == 0) $display("FAIL dir_underflow got output %h expected none", outs());
        else begin
          e = sb.pop_front();
          if (outs() !== e) $display("FAIL dir_result cyc %0d got %h expected %h", cyc, outs(), e); else passed++;
        end
      end
      if (i_valid && o_ready) sb.push_back(vx[cyc]);
    end
    total++;
    if (sb.size() != 0) $display("FAIL dir_leftover got %0d expected 0", sb.size()); else passed++;
  endtask

  task automatic test_backpressure();
    logic [15:0] vm[3] = '{16'h0100, 16'h0030, 16'h0000};
    logic [7:0]  ve[3] = '{8'd20, 8'd7, 8'd3};
    int   sent = 0;
    int   got  = 0;
    res_t e;
    res_t held;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge i_clk);
      i_ready = (cyc < 2) || (cyc >= 6);
      i_valid = (sent < 3);
      if (sent < 3) begin
        i_mant = vm[sent];
        i_exp  = ve[sent];
        i_sign = sent[0];
      end
      #1;
      if (cyc == 2) begin
        held = outs();
        total++;
        if (sent != 2) $display("FAIL bp_accepts_before_stall got %0d expected 2", sent); else passed++;
      end
      if (cyc >= 2 && cyc < 6) begin
        total++;
        if (o_ready !== 1'b0) $display("FAIL bp_ready_low cyc %0d got %b expected 0", cyc, o_ready); else passed++;
        total++;
        if (o_valid !== 1'b1 || outs() !== held)
          $display("FAIL bp_stable cyc %0d got %b/%h expected 1/%h", cyc, o_valid, outs(), held);
        else passed++;
      end
      if (o_valid && i_ready) begin
        total++;
        got++;
        if (sb.size() == 0) $display("FAIL bp_underflow got output %h expected none", outs());
        else begin
          e = sb.pop_front();
          if (outs() !== e) $display("FAIL bp_result cyc %0d got %h expected %h", cyc, outs(), e); else passed++;
        end
      end
      if (i_valid && o_ready) begin
        sb.push_back(model(i_mant, i_exp, i_sign));
        sent++;
      end
    end
    i_valid = 1'b0;
    total++;
    if (got != 3 || sb.size() != 0) $display("FAIL bp_count got %0d results expected 3", got); else passed++;
  endtask

  task automatic test_back_to_back();
    int   sent = 0;
    int   got  = 0;
    logic pend = 1'b0;
    logic stalled = 1'b0;
    res_t prev;
    res_t e;
    logic [31:0] r;
    i_valid = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge i_clk);
      if (!pend) begin
        i_valid = (cyc < 260) && ($urandom_range(0, 9) < 8);
        r       = $urandom;
        i_mant  = r[15:0] >> $urandom_range(0, 16);
        i_exp   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 16)) : 8'($urandom_range(0, 255));
        i_sign  = r[31];
      end
      i_ready = (cyc >= 260) || ($urandom_range(0, 9) < 7);
      #1;
      if (stalled) begin
        total++;
        if (o_valid !== 1'b1 || outs() !== prev)
          $display("FAIL b2b_stall_stable cyc %0d got %b/%h expected 1/%h", cyc, o_valid, outs(), prev);
        else passed++;
      end
      stalled = o_valid && !i_ready;
      prev    = outs();
      if (o_valid && i_ready) begin
        total++;
        got++;
        if (sb.size() == 0) $display("FAIL b2b_underflow got output %h expected none", outs());
        else begin
          e = sb.pop_front();
          if (outs() !== e) $display("FAIL b2b_result cyc %0d got %h expected %h", cyc, outs(), e); else passed++;
        end
      end
      if (i_valid && o_ready) begin
        sb.push_back(model(i_mant, i_exp, i_sign));
        sent++;
        pend = 1'b0;
      end else begin
        pend = i_valid;
      end
    end
    i_valid = 1'b0;
    total++;
    if (got != sent || sb.size() != 0) $display("FAIL b2b_count got %0d results expected %0d", got, sent); else passed++;
  endtask

  task automatic test_reset_mid();
    @(negedge i_clk);
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_mant  = 16'h0100;
    i_exp   = 8'd20;
    i_sign  = 1'b1;
    @(negedge i_clk);
    i_mant  = 16'h0F00;
    i_exp   = 8'd30;
    @(negedge i_clk);
    i_valid = 1'b0;
    #1;
    total++;
    if (o_valid !== 1'b1 || o_ready !== 1'b0)
      $display("FAIL rm_full_before_reset got %b%b expected 10", o_valid, o_ready);
    else passed++;
    i_rst_n = 1'b0;
    #1;
    total++;
    if (o_ready !== 1'b0) $display("FAIL rm_ready_in_reset got %b expected 0", o_ready); else passed++;
    @(negedge i_clk);
    #1;
    total++;
    if ({o_valid, outs()} !== 28'h0) $display("FAIL rm_cleared got %h expected 0", {o_valid, outs()}); else passed++;
    total++;
    if (o_ready !== 1'b0) $display("FAIL rm_ready_held got %b expected 0", o_ready); else passed++;
    i_rst_n = 1'b1;
    #1;
    total++;
    if (o_ready !== 1'b1) $display("FAIL rm_ready_release got %b expected 1", o_ready); else passed++;
    sb.delete();
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge i_clk);
      i_ready = 1'b1;
      #1;
      total++;
      if (o_valid !== 1'b0) $display("FAIL rm_no_stale cyc %0d got %b expected 0", cyc, o_valid); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
